mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_iter.sv | 139 +++++++++++++
 tb/tb_mdu_iter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO result registers (radix-2, one bit per cycle).
// Optional build macro MDU_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state;
  logic [WIDTH-1:0]     hi, lo;
  logic [CW-1:0]        cnt;
  logic                 is_div, sgn_a, sgn_b, b_zero;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mc;
  logic [WIDTH-1:0]     mq;

  function automatic logic [WIDTH-1:0] cond_neg(input logic s, input logic [WIDTH-1:0] x);
    return s ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic s, input logic [2*WIDTH-1:0] x);
    return s ? (~x + 1'b1) : x;
  endfunction

  logic signed [WIDTH-1:0] a_sg, b_sg;
  logic                    sa_in, sb_in;
  logic [WIDTH-1:0]        mag_a, mag_b;

  assign a_sg  = a;
  assign b_sg  = b;
  assign sa_in = (op[0] == 1'b0) && (a_sg < 0);
  assign sb_in = (op[0] == 1'b0) && (b_sg < 0);
  assign mag_a = cond_neg(sa_in, a);
  assign mag_b = cond_neg(sb_in, b);

  // One iteration step: shift-add for multiply, trial subtraction for divide.
  logic [2*WIDTH-1:0] mul_acc_nx;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_nx;
  logic               last_run;

  assign mul_acc_nx = acc + (mq[0] ? mc : '0);
  assign div_shift  = {acc[WIDTH-1:0], mq[WIDTH-1]};
  assign div_diff   = {1'b0, div_shift} - {2'b00, mc[WIDTH-1:0]};
  assign div_ok     = ~div_diff[WIDTH+1];
  assign rem_nx     = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

`ifdef MDU_EARLY_TERM_EN
  assign last_run = (cnt == LAST) || (!is_div && (mq[WIDTH-1:1] == '0));
`else
  assign last_run = (cnt == LAST);
`endif

  assign out = (op == 3'b110) ? hi : lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      b_zero <= 1'b0;
      acc    <= '0;
      mc     <= '0;
      mq     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'b100) begin
              hi <= a;
            end else if (op == 3'b101) begin
              lo <= a;
            end else if (op[2] == 1'b0) begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= op[1];
              sgn_a  <= sa_in;
              sgn_b  <= sb_in;
              b_zero <= (b == '0);
              acc    <= '0;
              // Multiply walks b's magnitude; divide shifts a's magnitude out as quotient bits enter.
              mc     <= {{WIDTH{1'b0}}, (op[1] ? mag_b : mag_a)};
              mq     <= op[1] ? mag_a : mag_b;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= {{WIDTH{1'b0}}, rem_nx};
            mq  <= {mq[WIDTH-2:0], div_ok};
          end else begin
            acc <= mul_acc_nx;
            mc  <= mc << 1;
            mq  <= mq >> 1;
          end
          cnt <= cnt + 1'b1;
          if (last_run) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            // A zero divisor leaves the dividend magnitude in the remainder, so HI comes out as a.
            lo <= b_zero ? '1 : cond_neg(sgn_a ^ sgn_b, mq);
            hi <= cond_neg(sgn_a, acc[WIDTH-1:0]);
          end else begin
            {hi, lo} <= cond_neg2(sgn_a ^ sgn_b, acc);
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: scoreboarded HI/LO results, busy latency, done pulse, reset abort.
module tb_mdu_iter;
  localparam int W = 32;
`ifdef MDU_EARLY_TERM_EN
  localparam int IGN_CYC = 2;
`else
  localparam int IGN_CYC = 5;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b, out;
  logic         busy, done;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    int           cyc;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

`ifdef MDU_EARLY_TERM_EN
  function automatic int exp_busy(input logic [2:0] o, input logic [W-1:0] bv);
    logic [W-1:0] m;
    int n;
    if (o[1]) return W + 1;
    m = (o == 3'b000 && bv[W-1]) ? (~bv + 1'b1) : bv;
    n = 1;
    for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
    return n + 1;
  endfunction
`else
  function automatic int exp_busy(input logic [2:0] o, input logic [W-1:0] bv);
    return (o[1] || bv == '0 || bv != '0) ? W + 1 : W + 1;
  endfunction
`endif

  // Reference results from plain SV arithmetic, returned as {hi, lo}.
  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic signed [63:0] x, y, q, r;
    logic [63:0]        p;
    case (o)
      3'b000: begin
        x = 64'(signed'(av)); y = 64'(signed'(bv));
        p = x * y;
        return p;
      end
      3'b001: begin
        p = {32'h0, av} * {32'h0, bv};
        return p;
      end
      3'b010: begin
        if (bv == '0) return {av, {W{1'b1}}};
        x = 64'(signed'(av)); y = 64'(signed'(bv));
        q = x / y; r = x % y;
        return {r[W-1:0], q[W-1:0]};
      end
      default: begin
        if (bv == '0) return {av, {W{1'b1}}};
        return {av % bv, av / bv};
      end
    endcase
  endfunction

  task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
    op = 3'b110; #1 h = out;
    op = 3'b111; #1 l = out;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] hi_e,
                        input logic [W-1:0] lo_e, input int ign);
    exp_t e;
    int n;
    logic [W-1:0] h, l;
    e.tag = tag; e.cyc = exp_busy(o, bv); e.hi = hi_e; e.lo = lo_e;
    sb.push_back(e);
    @(negedge clk); start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk); start = 1'b0; a = $urandom; b = $urandom; n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == ign) begin start = 1'b1; op = 3'b100; a = 32'd55; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " busy_cycles"}, 64'(n), 64'(e.cyc));
    chk({e.tag, " done"}, 64'(done), 64'd1);
    read_hl(h, l);
    chk({e.tag, " hi"}, 64'(h), 64'(e.hi));
    chk({e.tag, " lo"}, 64'(l), 64'(e.lo));
    @(negedge clk);
    chk({e.tag, " done_drop"}, 64'(done), 64'd0);
  endtask

  task automatic run_model(input string tag, input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2*W-1:0] r;
    r = model(o, av, bv);
    run_op(tag, o, av, bv, r[2*W-1:W], r[W-1:0], 0);
  endtask

  task automatic move(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                      input logic [W-1:0] hi_e, input logic [W-1:0] lo_e);
    logic [W-1:0] h, l;
    @(negedge clk); start = 1'b1; op = o; a = av;
    @(negedge clk); start = 1'b0; a = $urandom;
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    read_hl(h, l);
    chk({tag, " hi"}, 64'(h), 64'(hi_e));
    chk({tag, " lo"}, 64'(l), 64'(lo_e));
  endtask

  initial begin
    logic [W-1:0] h, l;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    read_hl(h, l);
    chk("reset hi", 64'(h), 64'd0);
    chk("reset lo", 64'(l), 64'd0);
    @(negedge clk); reset = 1'b0;

    move("mthi", 3'b100, 32'h1234, 32'h1234, 32'h0);
    move("mtlo", 3'b101, 32'h5678, 32'h1234, 32'h5678);
    move("mfhi_noop", 3'b110, 32'hDEAD, 32'h1234, 32'h5678);
    move("mflo_noop", 3'b111, 32'hBEEF, 32'h1234, 32'h5678);

    run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 0);
    run_op("div_neg7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div_by_zero", 3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 0);
    run_op("divu_by_zero", 3'b011, 32'h9000_0001, 32'd0, 32'h9000_0001, 32'hFFFFFFFF, 0);
    run_op("div_min_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
    run_op("multu_ign", 3'b001, 32'd3, 32'd4, 32'h0, 32'd12, IGN_CYC);
    run_op("multu_5_3", 3'b001, 32'd5, 32'd3, 32'h0, 32'd15, 0);
    run_op("mult_max", 3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 3) rb = rb >> 20;
      run_model("random", 3'(i % 4), ra, rb);
    end

    // Abort a divide mid-RUN with an asynchronous reset pulse between clock edges.
    @(negedge clk); start = 1'b1; op = 3'b011; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    read_hl(h, l);
    chk("abort hi", 64'(h), 64'd0);
    chk("abort lo", 64'(l), 64'd0);
    @(negedge clk); reset = 1'b0;
    run_op("post_reset_multu", 3'b001, 32'd2, 32'd3, 32'h0, 32'd6, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
